// File: rtl/avalon_mm_cmd_master.sv
// avalon_mm_cmd_master
// Command-driven Avalon-MM master. Takes single-word read/write commands on a
// valid/ready port, issues one Avalon transfer per command while honouring
// AVALON_WAITREQUEST, tracks pipelined read returns via AVALON_READDATAVALID
// and hands read data back through a show-ahead response FIFO.
//
// Ports:
//   CLK, nRST                 clock (posedge) and asynchronous active-low reset
//   CMD_VALID / CMD_READY     command handshake
//   CMD_WRITE                 1 = write, 0 = read
//   CMD_ADDR, CMD_BE,
//   CMD_WDATA                 command address, byte enables, write data
//   AVALON_*                  Avalon-MM master port toward the slave bridge
//   RSP_VALID / RSP_READY     response FIFO handshake (pop on both high)
//   RSP_DATA                  FIFO head, show-ahead, 0 when empty
//   ERR_TIMEOUT               sticky, waitrequest timeout abort occurred
//   ERR_UNEXP                 sticky, read data arrived with no read pending
module avalon_mm_cmd_master #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int RSP_DEPTH = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic                  CMD_WRITE,
  input  logic [ADDR_W-1:0]     CMD_ADDR,
  input  logic [DATA_W/8-1:0]   CMD_BE,
  input  logic [DATA_W-1:0]     CMD_WDATA,
  output logic [ADDR_W-1:0]     AVALON_ADDRESS,
  output logic [DATA_W/8-1:0]   AVALON_BYTEENABLE,
  output logic                  AVALON_READ,
  output logic                  AVALON_WRITE,
  output logic [DATA_W-1:0]     AVALON_WRITEDATA,
  input  logic                  AVALON_WAITREQUEST,
  input  logic [DATA_W-1:0]     AVALON_READDATA,
  input  logic                  AVALON_READDATAVALID,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_W-1:0]     RSP_DATA,
  output logic                  ERR_TIMEOUT,
  output logic                  ERR_UNEXP
);

  localparam int PTR_W  = $clog2(RSP_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // The abort fires on the wait cycle that would bring the count to TIMEOUT.
  localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_REQ  = 1'b1;

  logic              state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  pending;
  logic [CNT_W-1:0]  fifo_count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] mem [RSP_DEPTH];

  logic [CNT_W:0]    in_use;
  logic              credit_ok;
  logic              cmd_fire;
  logic              xfer_accept;
  logic              xfer_abort;
  logic              read_accept;
  logic              push;
  logic              pop;

  // Outstanding reads plus buffered responses may never exceed the FIFO
  // depth, so every read issued is guaranteed a slot for its data.
  assign in_use    = {1'b0, pending} + {1'b0, fifo_count};
  assign credit_ok = in_use < (CNT_W+1)'(RSP_DEPTH);

  // Gated by nRST so the port reads 0 while reset is held.
  assign CMD_READY   = nRST & (state == STATE_IDLE) & credit_ok;
  assign cmd_fire    = CMD_VALID & CMD_READY;
  assign xfer_accept = (state == STATE_REQ) & ~AVALON_WAITREQUEST;
  assign xfer_abort  = (TIMEOUT > 0) && (state == STATE_REQ) && AVALON_WAITREQUEST &&
                       (wait_cnt == WAIT_LAST);
  assign read_accept = xfer_accept & AVALON_READ;
  assign push        = AVALON_READDATAVALID & (pending != '0);
  assign pop         = RSP_VALID & RSP_READY;

  assign RSP_VALID = (fifo_count != '0);
  assign RSP_DATA  = RSP_VALID ? mem[rd_ptr] : '0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state             <= STATE_IDLE;
      wait_cnt          <= '0;
      AVALON_ADDRESS    <= '0;
      AVALON_BYTEENABLE <= '0;
      AVALON_WRITEDATA  <= '0;
      AVALON_READ       <= 1'b0;
      AVALON_WRITE      <= 1'b0;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (cmd_fire) begin
            AVALON_ADDRESS    <= CMD_ADDR;
            AVALON_BYTEENABLE <= CMD_BE;
            AVALON_WRITEDATA  <= CMD_WDATA;
            AVALON_READ       <= ~CMD_WRITE;
            AVALON_WRITE      <= CMD_WRITE;
            wait_cnt          <= '0;
            state             <= STATE_REQ;
          end
        end
        STATE_REQ: begin
          // Address/data registers are left holding their last values.
          if (xfer_accept || xfer_abort) begin
            AVALON_READ  <= 1'b0;
            AVALON_WRITE <= 1'b0;
            state        <= STATE_IDLE;
          end else if (TIMEOUT > 0) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ERR_TIMEOUT <= 1'b0;
      ERR_UNEXP   <= 1'b0;
    end else begin
      if (xfer_abort)
        ERR_TIMEOUT <= 1'b1;
      if (AVALON_READDATAVALID && (pending == '0))
        ERR_UNEXP <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pending    <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      case ({read_accept, push})
        2'b10:   pending <= pending + CNT_W'(1);
        2'b01:   pending <= pending - CNT_W'(1);
        default: pending <= pending;
      endcase
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      // Depth is a power of two, so the pointers wrap naturally.
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage needs no reset: RSP_DATA is masked while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (push)
      mem[wr_ptr] <= AVALON_READDATA;
  end

endmodule

// File: tb/tb_avalon_mm_cmd_master.sv
// tb_avalon_mm_cmd_master
// Self-checking bench for avalon_mm_cmd_master (RSP_DEPTH = 4, TIMEOUT = 8).
// A cycle table covers the plain write and the wait-stated read; hand
// sequences cover credit limiting, timeout abort, unexpected read data and a
// reset taken in the middle of a transfer.
module tb_avalon_mm_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [3:0]  cmd_be;
  logic [31:0] cmd_wdata;
  logic [15:0] avalon_address;
  logic [3:0]  avalon_byteenable;
  logic        avalon_read;
  logic        avalon_write;
  logic [31:0] avalon_writedata;
  logic        wait_req;
  logic [31:0] rdata;
  logic        rdv;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        err_timeout;
  logic        err_unexp;

  int total_checks = 0;
  int fail_checks  = 0;

  int          issued;
  logic        ret_pend;
  logic [31:0] ret_data;
  int          high_cnt;

  typedef struct {
    logic        cmd_valid;
    logic        cmd_write;
    logic [15:0] addr;
    logic [3:0]  be;
    logic        wait_req;
    logic        rdv;
    logic [31:0] rdata;
    logic        rsp_ready;
    logic        exp_ready;
    logic        exp_read;
    logic        exp_write;
    logic [15:0] exp_addr;
    logic [3:0]  exp_be;
    logic        exp_rsp_valid;
    logic [31:0] exp_rsp_data;
  } vec_t;

  vec_t vecs [11];

  avalon_mm_cmd_master #(
    .ADDR_W(16), .DATA_W(32), .RSP_DEPTH(4), .TIMEOUT(8)
  ) dut (
    .CLK(clk),
    .nRST(rst_n),
    .CMD_VALID(cmd_valid),
    .CMD_READY(cmd_ready),
    .CMD_WRITE(cmd_write),
    .CMD_ADDR(cmd_addr),
    .CMD_BE(cmd_be),
    .CMD_WDATA(cmd_wdata),
    .AVALON_ADDRESS(avalon_address),
    .AVALON_BYTEENABLE(avalon_byteenable),
    .AVALON_READ(avalon_read),
    .AVALON_WRITE(avalon_write),
    .AVALON_WRITEDATA(avalon_writedata),
    .AVALON_WAITREQUEST(wait_req),
    .AVALON_READDATA(rdata),
    .AVALON_READDATAVALID(rdv),
    .RSP_VALID(rsp_valid),
    .RSP_READY(rsp_ready),
    .RSP_DATA(rsp_data),
    .ERR_TIMEOUT(err_timeout),
    .ERR_UNEXP(err_unexp)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total_checks++;
    if (actual !== expected) begin
      fail_checks++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input vec_t v);
    cmd_valid = v.cmd_valid;
    cmd_write = v.cmd_write;
    cmd_addr  = v.addr;
    cmd_be    = v.be;
    cmd_wdata = 32'hA5A5_0001;
    wait_req  = v.wait_req;
    rdv       = v.rdv;
    rdata     = v.rdata;
    rsp_ready = v.rsp_ready;
  endtask

  // Keeps CMD_VALID high with reads to 0x0100 + n; the slave model accepts
  // immediately and returns 0xD000_0000 | address one cycle after acceptance.
  task automatic run_reads(input int cycles);
    logic        hs;
    logic        acc;
    logic [15:0] acc_addr;
    for (int c = 0; c < cycles; c++) begin
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 16'h0100 + issued[15:0];
      cmd_be    = 4'hF;
      wait_req  = 1'b0;
      rdv       = ret_pend;
      rdata     = ret_data;
      hs        = cmd_ready;
      acc       = avalon_read;
      acc_addr  = avalon_address;
      step();
      if (hs)
        issued++;
      ret_pend = acc;
      ret_data = 32'hD000_0000 | {16'h0000, acc_addr};
    end
    cmd_valid = 1'b0;
    rdv       = 1'b0;
  endtask

  initial begin
    // inputs: valid write addr be wait rdv rdata rsp_ready
    // expected after edge: ready read write addr be rsp_valid rsp_data
    vecs[0]  = '{1'b1, 1'b1, 16'h0010, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0,
                 1'b0, 1'b0, 1'b1, 16'h0010, 4'hF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 16'hFFFF, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                 1'b1, 1'b0, 1'b0, 16'h0010, 4'hF, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 16'hFFFF, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                 1'b1, 1'b0, 1'b0, 16'h0010, 4'hF, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 16'h0004, 4'h3, 1'b1, 1'b0, 32'h0, 1'b0,
                 1'b0, 1'b1, 1'b0, 16'h0004, 4'h3, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 16'hFFFF, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0,
                 1'b0, 1'b1, 1'b0, 16'h0004, 4'h3, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 1'b0, 16'hFFFF, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0,
                 1'b0, 1'b1, 1'b0, 16'h0004, 4'h3, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 1'b0, 16'hFFFF, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0,
                 1'b0, 1'b1, 1'b0, 16'h0004, 4'h3, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 1'b0, 16'hFFFF, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                 1'b1, 1'b0, 1'b0, 16'h0004, 4'h3, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 1'b0, 16'hFFFF, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                 1'b1, 1'b0, 1'b0, 16'h0004, 4'h3, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 1'b0, 16'hFFFF, 4'h0, 1'b0, 1'b1, 32'h1234_5678, 1'b0,
                 1'b1, 1'b0, 1'b0, 16'h0004, 4'h3, 1'b1, 32'h1234_5678};
    vecs[10] = '{1'b0, 1'b0, 16'hFFFF, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1,
                 1'b1, 1'b0, 1'b0, 16'h0004, 4'h3, 1'b0, 32'h0};

    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_be = '0;
    cmd_wdata = '0; wait_req = 1'b0; rdv = 1'b0; rdata = '0; rsp_ready = 1'b0;
    issued = 0; ret_pend = 1'b0; ret_data = '0;
    rst_n = 1'b0;

    // Reset state
    step();
    step();
    check_output("reset cmd_ready", cmd_ready, 0);
    check_output("reset read", avalon_read, 0);
    check_output("reset write", avalon_write, 0);
    check_output("reset address", avalon_address, 0);
    check_output("reset rsp_valid", rsp_valid, 0);
    check_output("reset rsp_data", rsp_data, 0);
    check_output("reset err_timeout", err_timeout, 0);
    check_output("reset err_unexp", err_unexp, 0);
    rst_n = 1'b1;
    step();
    check_output("idle cmd_ready", cmd_ready, 1);

    // Write without wait, then read with three wait states
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i]);
      step();
      check_output($sformatf("vec%0d cmd_ready", i), cmd_ready, vecs[i].exp_ready);
      check_output($sformatf("vec%0d read", i), avalon_read, vecs[i].exp_read);
      check_output($sformatf("vec%0d write", i), avalon_write, vecs[i].exp_write);
      check_output($sformatf("vec%0d address", i), avalon_address, vecs[i].exp_addr);
      check_output($sformatf("vec%0d byteenable", i), avalon_byteenable, vecs[i].exp_be);
      check_output($sformatf("vec%0d writedata", i), avalon_writedata, 32'hA5A5_0001);
      check_output($sformatf("vec%0d rsp_valid", i), rsp_valid, vecs[i].exp_rsp_valid);
      check_output($sformatf("vec%0d rsp_data", i), rsp_data, vecs[i].exp_rsp_data);
    end
    rsp_ready = 1'b0;
    check_output("table err_unexp", err_unexp, 0);

    // Credit limit: four reads fill the credit, one pop frees one more
    run_reads(20);
    check_output("credit issued", issued, 4);
    check_output("credit cmd_ready", cmd_ready, 0);
    check_output("credit rsp_valid", rsp_valid, 1);
    check_output("credit head", rsp_data, 32'hD000_0100);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check_output("credit head after pop", rsp_data, 32'hD000_0101);
    run_reads(10);
    check_output("credit issued after pop", issued, 5);
    check_output("credit cmd_ready after pop", cmd_ready, 0);
    for (int k = 0; k < 4; k++) begin
      check_output($sformatf("drain%0d rsp_valid", k), rsp_valid, 1);
      check_output($sformatf("drain%0d rsp_data", k), rsp_data, 32'hD000_0101 + k);
      rsp_ready = 1'b1;
      step();
    end
    rsp_ready = 1'b0;
    check_output("drain empty", rsp_valid, 0);
    check_output("credit err_unexp", err_unexp, 0);

    // Timeout abort on a read with waitrequest stuck high
    check_output("pre timeout err", err_timeout, 0);
    wait_req  = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0200; cmd_be = 4'hF;
    step();
    cmd_valid = 1'b0;
    high_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (!avalon_read)
        break;
      high_cnt++;
      step();
    end
    check_output("timeout read cycles", high_cnt, 8);
    check_output("timeout err_timeout", err_timeout, 1);
    check_output("timeout cmd_ready", cmd_ready, 1);
    check_output("timeout rsp_valid", rsp_valid, 0);
    wait_req  = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0220; cmd_wdata = 32'h5555_AAAA;
    step();
    cmd_valid = 1'b0;
    check_output("post timeout write", avalon_write, 1);
    check_output("post timeout address", avalon_address, 16'h0220);
    check_output("post timeout writedata", avalon_writedata, 32'h5555_AAAA);
    step();
    check_output("post timeout write done", avalon_write, 0);

    // Unexpected read data (the aborted read left nothing pending)
    check_output("pre unexp err", err_unexp, 0);
    rdv = 1'b1; rdata = 32'hDEAD_BEEF;
    step();
    rdv = 1'b0;
    check_output("unexp err_unexp", err_unexp, 1);
    check_output("unexp rsp_valid", rsp_valid, 0);
    check_output("unexp cmd_ready", cmd_ready, 1);

    // Reset during REQ with two reads pending
    for (int r = 0; r < 2; r++) begin
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0300 + 16'(4 * r); cmd_be = 4'hF;
      step();
      cmd_valid = 1'b0;
      step();
    end
    wait_req  = 1'b1;
    cmd_valid = 1'b1; cmd_addr = 16'h0308;
    step();
    cmd_valid = 1'b0;
    step();
    check_output("pre reset read", avalon_read, 1);
    rst_n = 1'b0;
    #1;
    check_output("async cmd_ready", cmd_ready, 0);
    check_output("async read", avalon_read, 0);
    check_output("async write", avalon_write, 0);
    check_output("async address", avalon_address, 0);
    check_output("async byteenable", avalon_byteenable, 0);
    check_output("async writedata", avalon_writedata, 0);
    check_output("async rsp_valid", rsp_valid, 0);
    check_output("async rsp_data", rsp_data, 0);
    check_output("async err_timeout", err_timeout, 0);
    check_output("async err_unexp", err_unexp, 0);
    wait_req = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    check_output("post reset cmd_ready", cmd_ready, 1);
    check_output("post reset err_unexp", err_unexp, 0);
    for (int p = 0; p < 2; p++) begin
      rdv = 1'b1; rdata = 32'h1111_0000 + p;
      step();
      rdv = 1'b0;
      check_output($sformatf("stale%0d err_unexp", p), err_unexp, 1);
      check_output($sformatf("stale%0d rsp_valid", p), rsp_valid, 0);
    end

    $display("%0d/%0d checks passed", total_checks - fail_checks, total_checks);
    $finish;
  end

endmodule
